// File: rtl/bar_update_arb.sv
// bar_update_arb: round-robin write arbiter for eight bar registers with dirty tracking and rate-limited refresh handshake
module bar_update_arb #(
  parameter int NREQ = 3,
  parameter int HOLDOFF = 16,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ,
  input  logic [3*NREQ-1:0]   ADDR,
  input  logic [8*NREQ-1:0]   DATA,
  output logic [NREQ-1:0]     GNT,
  output logic [63:0]         BARS,
  output logic [7:0]          DIRTY,
  output logic                REF_REQ,
  input  logic                REF_ACK,
  output logic                BUSY
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = HOLDOFF > 2 ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] LOAD = HOLDOFF > 1 ? CW'(HOLDOFF - 1) : '0;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] ptr, hi, lo, win;
  logic hi_v, any, accept;
  logic [2:0] wa;
  logic [7:0] wd;
  // lowest requester at or above the pointer wins, else wrap to the lowest overall
  always_comb begin
    hi = '0;
    lo = '0;
    hi_v = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[i]) lo = PW'(i);
      if (REQ[i] && PW'(i) >= ptr) begin
        hi = PW'(i);
        hi_v = 1'b1;
      end
    end
    any = |REQ;
    win = hi_v ? hi : lo;
    wa = '0;
    wd = '0;
    for (int i = 0; i < NREQ; i++)
      if (win == PW'(i)) begin
        wa = ADDR[3*i +: 3];
        wd = DATA[8*i +: 8];
      end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    accept = 1'b0;
    case (state)
      S_IDLE: state_n = |DIRTY ? S_REQ : S_IDLE;
      S_REQ:
        if (REF_ACK) begin
          accept = 1'b1;
          state_n = HOLDOFF > 1 ? S_HOLD : S_IDLE;
          cnt_n = LOAD;
        end
      S_HOLD: begin
        state_n = cnt != '0 ? S_HOLD : (|DIRTY ? S_REQ : S_IDLE);
        cnt_n = cnt != '0 ? cnt - 1'b1 : cnt;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // a write granted on the accept cycle survives the dirty clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      BARS <= {8{RST_VAL}};
      DIRTY <= '0;
      GNT <= '0;
      ptr <= '0;
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      GNT <= any ? NREQ'(1) << win : '0;
      if (any) begin
        BARS[{wa, 3'b000} +: 8] <= wd;
        ptr <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
      end
      DIRTY <= (accept ? 8'h00 : DIRTY) | (any ? 8'(1) << wa : 8'h00);
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  assign REF_REQ = state == S_REQ;
  assign BUSY = state == S_REQ;
endmodule

// File: tb/tb_bar_update_arb.sv
// tb_bar_update_arb: directed plus randomized checks of bar_update_arb against a behavioural model
module tb_bar_update_arb;
  localparam int NREQ = 3;
  localparam int HOLDOFF = 16;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic REF_ACK = 1'b0;
  logic [NREQ-1:0] REQ;
  logic [3*NREQ-1:0] ADDR;
  logic [8*NREQ-1:0] DATA;
  logic [NREQ-1:0] GNT;
  logic [63:0] BARS;
  logic [7:0] DIRTY;
  logic REF_REQ, BUSY;
  logic req_a [NREQ];
  logic [2:0] addr_a [NREQ];
  logic [7:0] data_a [NREQ];
  int n_cmp = 0;
  int n_err = 0;

  assign REQ = {req_a[2], req_a[1], req_a[0]};
  assign ADDR = {addr_a[2], addr_a[1], addr_a[0]};
  assign DATA = {data_a[2], data_a[1], data_a[0]};

  bar_update_arb #(.NREQ(NREQ), .HOLDOFF(HOLDOFF), .RST_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR), .DATA(DATA), .GNT(GNT),
    .BARS(BARS), .DIRTY(DIRTY), .REF_REQ(REF_REQ), .REF_ACK(REF_ACK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // model: circular search after the last granted requester; refresh allowed HOLDOFF cycles after the last accept
  logic [7:0] bars_m [8];
  logic [7:0] dirty_m, old_m;
  logic [2:0] gnt_m;
  logic ref_m, acc_m;
  int last_g, last_ack, w_m, k_m;
  int cyc = 0;
  bit started = 0;

  always @(posedge CLK) begin
    cyc++;
    started = 1;
    if (RST) begin
      for (int s = 0; s < 8; s++) bars_m[s] = 8'h00;
      dirty_m = 8'h00;
      gnt_m = 3'b000;
      ref_m = 1'b0;
      last_g = NREQ - 1;
      last_ack = -100000;
    end else begin
      old_m = dirty_m;
      acc_m = ref_m && REF_ACK;
      if (acc_m) begin
        ref_m = 1'b0;
        last_ack = cyc;
      end else if (!ref_m && old_m != 8'h00 && cyc - last_ack >= HOLDOFF)
        ref_m = 1'b1;
      gnt_m = 3'b000;
      w_m = 0;
      for (int j = 1; j <= NREQ; j++) begin
        k_m = (last_g + j) % NREQ;
        if (gnt_m == 3'b000 && req_a[k_m]) begin
          gnt_m[k_m] = 1'b1;
          w_m = k_m;
        end
      end
      dirty_m = acc_m ? 8'h00 : old_m;
      if (gnt_m != 3'b000) begin
        last_g = w_m;
        bars_m[addr_a[w_m]] = data_a[w_m];
        dirty_m[addr_a[w_m]] = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    logic [63:0] exp_b;
    if (started) begin
      for (int s = 0; s < 8; s++) exp_b[8*s +: 8] = bars_m[s];
      check("gnt", 64'(GNT), 64'(gnt_m));
      check("bars", BARS, exp_b);
      check("dirty", 64'(DIRTY), 64'(dirty_m));
      check("ref_req", 64'(REF_REQ), 64'(ref_m));
      check("busy", 64'(BUSY), 64'(ref_m));
    end
  end

  initial begin
    logic [2:0] eg;
    logic [7:0] cd [3];
    cd[0] = 8'hA0; cd[1] = 8'hB1; cd[2] = 8'hC2;
    for (int k = 0; k < NREQ; k++) begin
      req_a[k] = 1'b0;
      addr_a[k] = 3'd0;
      data_a[k] = 8'h00;
    end
    tick(2);
    check("rst_bars", BARS, 64'h0);
    check("rst_dirty", 64'(DIRTY), 64'h0);
    check("rst_gnt", 64'(GNT), 64'h0);
    check("rst_ref_req", 64'(REF_REQ), 64'h0);
    check("rst_busy", 64'(BUSY), 64'h0);
    RST = 1'b0;
    REF_ACK = 1'b1;
    tick(3);
    check("idle_ack_ref_req", 64'(REF_REQ), 64'h0);
    check("idle_ack_busy", 64'(BUSY), 64'h0);
    check("idle_ack_dirty", 64'(DIRTY), 64'h0);
    REF_ACK = 1'b0;
    req_a[0] = 1'b1; addr_a[0] = 3'd2; data_a[0] = 8'h1F;
    tick(1);
    check("single_gnt", 64'(GNT), 64'h1);
    check("single_slot2", 64'(BARS[23:16]), 64'h1F);
    check("single_dirty", 64'(DIRTY), 64'h04);
    check("single_ref_early", 64'(REF_REQ), 64'h0);
    req_a[0] = 1'b0;
    tick(1);
    check("single_ref_rise", 64'(REF_REQ), 64'h1);
    tick(4);
    check("ref_held", 64'(REF_REQ), 64'h1);
    REF_ACK = 1'b1;
    tick(1);
    REF_ACK = 1'b0;
    check("ack_ref_fall", 64'(REF_REQ), 64'h0);
    check("ack_dirty_clr", 64'(DIRTY), 64'h0);
    tick(1);
    req_a[0] = 1'b1; addr_a[0] = 3'd5; data_a[0] = 8'h55;
    tick(1);
    check("hold_wr_gnt", 64'(GNT), 64'h1);
    check("hold_wr_dirty", 64'(DIRTY), 64'h20);
    req_a[0] = 1'b0;
    for (int i = 3; i <= 15; i++) begin
      tick(1);
      check("holdoff_ref_low", 64'(REF_REQ), 64'h0);
    end
    tick(1);
    check("holdoff_ref_rise", 64'(REF_REQ), 64'h1);
    REF_ACK = 1'b1;
    req_a[1] = 1'b1; addr_a[1] = 3'd7; data_a[1] = 8'h77;
    tick(1);
    REF_ACK = 1'b0;
    req_a[1] = 1'b0;
    check("coinc_gnt", 64'(GNT), 64'h2);
    check("coinc_dirty", 64'(DIRTY), 64'h80);
    check("coinc_slot7", 64'(BARS[63:56]), 64'h77);
    check("coinc_ref_fall", 64'(REF_REQ), 64'h0);
    tick(15);
    check("coinc_ref_low", 64'(REF_REQ), 64'h0);
    tick(1);
    check("coinc_ref_rise", 64'(REF_REQ), 64'h1);
    REF_ACK = 1'b1;
    tick(1);
    REF_ACK = 1'b0;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      req_a[k] = 1'b1;
      addr_a[k] = 3'(k);
      data_a[k] = cd[k];
    end
    for (int i = 0; i < 7; i++) begin
      tick(1);
      eg = 3'b001 << (i % 3);
      check("rotate_gnt", 64'(GNT), 64'(eg));
    end
    check("rotate_slots", 64'(BARS[23:0]), 64'hC2B1A0);
    req_a[1] = 1'b0;
    req_a[2] = 1'b0;
    for (int s = 0; s < 8; s++) begin
      addr_a[0] = 3'(s);
      data_a[0] = 8'(s * 17);
      tick(1);
      check("fill_gnt", 64'(GNT), 64'h1);
    end
    req_a[0] = 1'b0;
    check("fill_dirty", 64'(DIRTY), 64'hFF);
    check("fill_ref_req", 64'(REF_REQ), 64'h1);
    RST = 1'b1;
    tick(1);
    check("mid_rst_ref_req", 64'(REF_REQ), 64'h0);
    check("mid_rst_busy", 64'(BUSY), 64'h0);
    check("mid_rst_dirty", 64'(DIRTY), 64'h0);
    check("mid_rst_bars", BARS, 64'h0);
    RST = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      for (int k = 0; k < NREQ; k++)
        if (!req_a[k] || GNT[k]) begin
          req_a[k] = $urandom_range(0, 2) != 0;
          addr_a[k] = 3'($urandom_range(0, 7));
          data_a[k] = 8'($urandom_range(0, 255));
        end
      REF_ACK = REF_REQ ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      RST = $urandom_range(0, 499) == 0;
    end
    RST = 1'b0;
    REF_ACK = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bar_update_arb.md
Name: bar_update_arb

Overview:
- Shares the eight 8-bit bar value registers feeding the graph display driver between three write requesters.
- Requesters: SPI slave (host writes), quadrature decoder (count updates), keyboard scanner (key-driven edits).
- Round-robin arbiter grants one write per cycle into the register bank.
- Tracks dirty slots and schedules rate-limited refresh requests to the display driver over a req/ack handshake.

Parameters:
- NREQ, 3, number of requesters; fixed priority index 0 = SPI, 1 = quad, 2 = keyboard.
- HOLDOFF, 16, minimum CLK cycles from one refresh acknowledge to the next refresh request.
- RST_VAL, 0, reset value loaded into every bar register.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST  in  1  synchronous reset, active-high.
- REQ  in  NREQ  per-requester write request, level.
- ADDR  in  3*NREQ  slot index per requester; requester i uses bits [3i+2:3i].
- DATA  in  8*NREQ  write data per requester; requester i uses bits [8i+7:8i].
- GNT  out  NREQ  one-hot grant pulse, one cycle.
- BARS  out  64  bar registers; slot k at bits [8k+7:8k].
- DIRTY  out  8  per-slot modified-since-last-refresh flags.
- REF_REQ  out  1  refresh request to the display driver.
- REF_ACK  in  1  display driver has latched BARS and started a frame.
- BUSY  out  1  high while a refresh handshake is outstanding.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset (RST high at a CLK edge):
  - all BARS slots = RST_VAL; DIRTY = 0; GNT = 0; REF_REQ = 0; BUSY = 0.
  - RR pointer = 0; holdoff counter = 0 (expired); refresh FSM = IDLE.
  - Reset mid-handshake abandons the handshake; an REF_ACK seen while in IDLE is ignored.
- Arbitration:
  - Round-robin starting at the pointer; at most one GNT bit high per cycle.
  - Winner k: GNT[k] = 1 for exactly one cycle, registered on the cycle after REQ[k] is sampled.
  - After granting k, the pointer moves to (k+1) mod NREQ.
  - A requester must hold REQ, ADDR and DATA stable until it sees its GNT bit.
  - On the GNT cycle the requester drops REQ or presents its next write. A held REQ is re-arbitrated normally; no back-to-back grants to the same requester while another requester is waiting.
  - No REQ asserted: GNT = 0 and the pointer is unchanged.
- Write: the BARS slot ADDR[k] takes DATA[k] at the same edge that asserts GNT[k]. Registered write, so the new value is visible on BARS one cycle after REQ is sampled.
- Dirty tracking:
  - A granted write sets DIRTY[addr], even if the data is unchanged.
  - When REF_ACK is accepted, every DIRTY bit is cleared except a bit set by a write granted in the same cycle; that bit remains 1.
- Refresh FSM:
  - IDLE:
    - DIRTY != 0 and holdoff expired -> REQ: REF_REQ = 1, BUSY = 1.
  - REQ:
    - REF_REQ held high until REF_ACK = 1.
    - On REF_ACK: REF_REQ = 0, BUSY = 0, holdoff counter loaded with HOLDOFF-1, go to HOLD.
  - HOLD:
    - Counter decrements each cycle; at 0 -> IDLE.
    - Writes are still granted during HOLD and set DIRTY.
  - Arbitration is never stalled by the refresh FSM.
  - Boundary: REF_ACK asserted in the same cycle REF_REQ first rises counts as an accept.
  - Boundary: HOLDOFF = 0 or 1 means IDLE is re-entered the cycle after the accept.
- Widths: ADDR is 3 bits, so every value is a valid slot; no wrap or error handling is needed. The holdoff counter is sized for HOLDOFF.

Test Plan:
- Reset check: assert RST for 2 cycles -> BARS = 0, DIRTY = 0, GNT = 0, REF_REQ = 0; hold REF_ACK = 1 in IDLE -> no state change.
- Single write: SPI REQ with ADDR = 2, DATA = 0x1F -> GNT = 3'b001 on the next cycle; BARS[23:16] = 0x1F; DIRTY = 8'h04; REF_REQ rises the following cycle.
- Contention: all three REQ held continuously with slots 0/1/2 and data 0xA0/0xB1/0xC2 -> grants 001, 010, 100, 001, ... (strict rotation); each slot holds its data.
- Handshake and holdoff, HOLDOFF = 16:
  - REF_ACK pulsed 5 cycles after REF_REQ rises -> REF_REQ falls and DIRTY clears.
  - A write 2 cycles later -> DIRTY set, but REF_REQ stays low until 16 cycles after the ACK edge.
- Write coincident with ACK: quad write to slot 7 in the same cycle REF_ACK is accepted -> DIRTY = 8'h80 afterward; a new REF_REQ is issued after the holdoff.
- Reset during the REQ state with DIRTY = 8'hFF -> next cycle REF_REQ = 0, BUSY = 0, DIRTY = 0, BARS = RST_VAL.
